// File: rtl/exe_mem_stage.sv
// exe_mem_stage: execute stage plus EXE/MEM pipeline register.
// Selects operand B, runs the ALU and registers the result together with
// the pass-through control fields for the MEM stage.
// Build option EXE_MUL_EN adds an iterative shift-add multiplier (ealuc 1011)
// that holds the upstream pipeline through the stall output while it runs.
// Without EXE_MUL_EN, ealuc 1011 executes as an add and stall is tied low.
module exe_mem_stage #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic        ealuimm,
  input  logic [3:0]  ealuc,
  input  logic [4:0]  emux,
  input  logic [31:0] eRegOutA,
  input  logic [31:0] eRegOutB,
  input  logic [31:0] eExtended,
  output logic        mwreg,
  output logic        mm2reg,
  output logic        mwmem,
  output logic [4:0]  mmux,
  output logic [31:0] mAluOut,
  output logic [31:0] mRegOutB,
  output logic        stall
);

  // Single-cycle ALU. The mul code yields 0 when the multiplier is built in
  // (only reachable as a bubble, ewreg=0), and add otherwise.
  function automatic logic [31:0] alu_f(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = 32'd0;
    casez (op)
      4'b1011: begin
`ifdef EXE_MUL_EN
        r = 32'd0;
`else
        r = a + b;
`endif
      end
      4'b0011: r = b << a[4:0];
      4'b0111: r = b >> a[4:0];
      4'b1111: r = $signed(b) >>> a[4:0];
      4'b?000: r = a + b;
      4'b?100: r = a - b;
      4'b?001: r = a & b;
      4'b?101: r = a | b;
      4'b?010: r = a ^ b;
      4'b?110: r = b << 16;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [31:0] b_s;
  logic [31:0] alu_s;
  logic        stall_s;

  logic        mwreg_d, mm2reg_d, mwmem_d;
  logic [4:0]  mmux_d;
  logic [31:0] malu_d, mrb_d;

  assign b_s   = ealuimm ? eExtended : eRegOutB;
  assign alu_s = alu_f(ealuc, eRegOutA, b_s);

`ifdef EXE_MUL_EN
  localparam int MUL_STEPS = 32 / MUL_BITS_PER_CYCLE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] mc_q, mc_d;    // multiplicand, shifted left each step
  logic [31:0] mp_q, mp_d;    // multiplier, shifted right each step
  logic [31:0] acc_q, acc_d;  // running low 32 bits of the product
  logic [31:0] part_s;
  logic        mul_req_s;

  assign mul_req_s = (ealuc == 4'b1011) & ewreg;

  // Partial product for the multiplier bits retired this cycle.
  always_comb begin
    part_s = 32'd0;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
      if (mp_q[j]) begin
        part_s = part_s + (mc_q << j);
      end else begin
        part_s = part_s;
      end
    end
  end

  // Multiplier FSM next state plus EXE/MEM next values; bubbles while busy.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    acc_d    = acc_q;
    stall_s  = 1'b0;
    mwreg_d  = ewreg;
    mm2reg_d = em2reg;
    mwmem_d  = ewmem;
    mmux_d   = emux;
    malu_d   = alu_s;
    mrb_d    = eRegOutB;
    case (state_q)
      S_IDLE: begin
        if (mul_req_s) begin
          stall_s  = 1'b1;
          mc_d     = eRegOutA;
          mp_d     = b_s;
          acc_d    = 32'd0;
          cnt_d    = 6'd0;
          state_d  = S_BUSY;
          mwreg_d  = 1'b0;
          mm2reg_d = 1'b0;
          mwmem_d  = 1'b0;
          mmux_d   = mmux;
          malu_d   = mAluOut;
          mrb_d    = mRegOutB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        stall_s  = 1'b1;
        acc_d    = acc_q + part_s;
        mc_d     = mc_q << MUL_BITS_PER_CYCLE;
        mp_d     = mp_q >> MUL_BITS_PER_CYCLE;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'(MUL_STEPS - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
        mwreg_d  = 1'b0;
        mm2reg_d = 1'b0;
        mwmem_d  = 1'b0;
        mmux_d   = mmux;
        malu_d   = mAluOut;
        mrb_d    = mRegOutB;
      end
      S_DONE: begin
        malu_d  = acc_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Multiplier FSM and datapath registers; reset aborts any multiply.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      mc_q    <= 32'd0;
      mp_q    <= 32'd0;
      acc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      acc_q   <= acc_d;
    end
  end

  // Gate with reset so a held mul request cannot stall while in reset.
  assign stall = stall_s & clrn;
`else
  // EXE/MEM next values: every operation is single-cycle.
  always_comb begin
    stall_s  = 1'b0;
    mwreg_d  = ewreg;
    mm2reg_d = em2reg;
    mwmem_d  = ewmem;
    mmux_d   = emux;
    malu_d   = alu_s;
    mrb_d    = eRegOutB;
  end

  assign stall = stall_s;
`endif

  // EXE/MEM pipeline register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mwreg    <= 1'b0;
      mm2reg   <= 1'b0;
      mwmem    <= 1'b0;
      mmux     <= 5'd0;
      mAluOut  <= 32'd0;
      mRegOutB <= 32'd0;
    end else begin
      mwreg    <= mwreg_d;
      mm2reg   <= mm2reg_d;
      mwmem    <= mwmem_d;
      mmux     <= mmux_d;
      mAluOut  <= malu_d;
      mRegOutB <= mrb_d;
    end
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed bench for exe_mem_stage. Instance A uses one multiplier bit per
// cycle, instance B four; both share the inputs and only one is out of reset
// at a time. Multiplier scenarios are built only when EXE_MUL_EN is defined.
module tb_exe_mem_stage;

  logic        clk = 1'b0;
  logic        clrn_a, clrn_b;
  logic        ewreg, em2reg, ewmem, ealuimm;
  logic [3:0]  ealuc;
  logic [4:0]  emux;
  logic [31:0] eRegOutA, eRegOutB, eExtended;

  logic        a_mwreg, a_mm2reg, a_mwmem, a_stall;
  logic [4:0]  a_mmux;
  logic [31:0] a_alu, a_rb;
  logic        b_mwreg, b_mm2reg, b_mwmem, b_stall;
  logic [4:0]  b_mmux;
  logic [31:0] b_alu, b_rb;

  logic        sel_b = 1'b0;
  logic        o_mwreg, o_mm2reg, o_mwmem, o_stall;
  logic [4:0]  o_mmux;
  logic [31:0] o_alu, o_rb;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  exe_mem_stage #(.MUL_BITS_PER_CYCLE(1)) dut_a (
    .clk(clk), .clrn(clrn_a), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuimm(ealuimm), .ealuc(ealuc), .emux(emux), .eRegOutA(eRegOutA),
    .eRegOutB(eRegOutB), .eExtended(eExtended), .mwreg(a_mwreg),
    .mm2reg(a_mm2reg), .mwmem(a_mwmem), .mmux(a_mmux), .mAluOut(a_alu),
    .mRegOutB(a_rb), .stall(a_stall));

  exe_mem_stage #(.MUL_BITS_PER_CYCLE(4)) dut_b (
    .clk(clk), .clrn(clrn_b), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealuimm(ealuimm), .ealuc(ealuc), .emux(emux), .eRegOutA(eRegOutA),
    .eRegOutB(eRegOutB), .eExtended(eExtended), .mwreg(b_mwreg),
    .mm2reg(b_mm2reg), .mwmem(b_mwmem), .mmux(b_mmux), .mAluOut(b_alu),
    .mRegOutB(b_rb), .stall(b_stall));

  assign o_mwreg  = sel_b ? b_mwreg  : a_mwreg;
  assign o_mm2reg = sel_b ? b_mm2reg : a_mm2reg;
  assign o_mwmem  = sel_b ? b_mwmem  : a_mwmem;
  assign o_stall  = sel_b ? b_stall  : a_stall;
  assign o_mmux   = sel_b ? b_mmux   : a_mmux;
  assign o_alu    = sel_b ? b_alu    : a_alu;
  assign o_rb     = sel_b ? b_rb     : a_rb;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic m2, input logic wm,
                       input logic imm, input logic [3:0] c,
                       input logic [4:0] mux, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ext);
    ewreg = w; em2reg = m2; ewmem = wm; ealuimm = imm; ealuc = c;
    emux = mux; eRegOutA = a; eRegOutB = b; eExtended = ext;
  endtask

  task automatic test_reset;
    clrn_a = 1'b0;
    clrn_b = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 32'd0, 32'd0, 32'd0);
    #3;
    vec_cnt++;
    if ({o_mwreg, o_mm2reg, o_mwmem, o_mmux, o_alu, o_rb} !== 72'd0 || o_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state got alu=%h rb=%h ctl=%b mux=%0d stall=%b exp all zero",
               o_alu, o_rb, {o_mwreg, o_mm2reg, o_mwmem}, o_mmux, o_stall);
    end
    tick;
    clrn_a = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd2, 32'd10, 32'd20, 32'd0);
    tick;
    vec_cnt++;
    if (o_alu !== 32'd30 || o_mwreg !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_reset_add got alu=%h wreg=%b exp 0000001e 1", o_alu, o_mwreg);
    end
`ifdef EXE_MUL_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 5'd9, 32'd5, 32'd6, 32'd0);
    for (int i = 0; i < 6; i++) tick;
    vec_cnt++;
    if (o_stall !== 1'b1 || o_mwreg !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_mul_busy got stall=%b wreg=%b exp 1 0", o_stall, o_mwreg);
    end
    clrn_a = 1'b0;
    #1;
    vec_cnt++;
    if ({o_mwreg, o_mm2reg, o_mwmem, o_mmux, o_alu, o_rb} !== 72'd0 || o_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_mul got alu=%h rb=%h mux=%0d stall=%b exp all zero",
               o_alu, o_rb, o_mmux, o_stall);
    end
`endif
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd3, 32'd3, 32'd4, 32'd0);
    #2;
    clrn_a = 1'b1;
    tick;
    vec_cnt++;
    if (o_alu !== 32'd7 || o_mwreg !== 1'b1 || o_mmux !== 5'd3) begin
      err_cnt++;
      $display("FAIL add_after_reset got alu=%h wreg=%b mux=%0d exp 00000007 1 3",
               o_alu, o_mwreg, o_mmux);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      vec_cnt++;
      if (o_mwreg !== 1'b0 || o_stall !== 1'b0) begin
        err_cnt++;
        $display("FAIL no_aborted_result got wreg=%b stall=%b exp 0 0", o_mwreg, o_stall);
      end
    end
  endtask

  task automatic test_alu;
    logic [3:0]  codes [9];
    logic [31:0] expv  [9];
    codes = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
              4'b0011, 4'b0110, 4'b0111, 4'b1000};
    expv  = '{32'hFFFFF1EF, 32'hE1E1EFF1, 32'h000000F0, 32'hFFFFF0FF, 32'hFFFFF00F,
              32'h00FF0000, 32'h00FF0000, 32'h00000F0F, 32'hFFFFF1EF};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, i[0], i[1], 1'b0, codes[i], 5'(i + 1), 32'hF0F0F0F0,
            32'h0F0F00FF, 32'h55555555);
      tick;
      vec_cnt++;
      if (o_alu !== expv[i] || o_mmux !== 5'(i + 1) || o_rb !== 32'h0F0F00FF ||
          {o_mwreg, o_mm2reg, o_mwmem} !== {1'b1, i[0], i[1]}) begin
        err_cnt++;
        $display("FAIL alu_op_%b got alu=%h mux=%0d rb=%h ctl=%b exp alu=%h mux=%0d",
                 codes[i], o_alu, o_mmux, o_rb, {o_mwreg, o_mm2reg, o_mwmem},
                 expv[i], i + 1);
      end
    end
  endtask

  task automatic test_imm_sra;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 5'd17, 32'd4, 32'h12345678, 32'hFFFF8000);
    tick;
    vec_cnt++;
    if (o_alu !== 32'hFFFFF800 || o_rb !== 32'h12345678 || o_mmux !== 5'd17) begin
      err_cnt++;
      $display("FAIL imm_sra got alu=%h rb=%h mux=%0d exp fffff800 12345678 17",
               o_alu, o_rb, o_mmux);
    end
  endtask

`ifdef EXE_MUL_EN
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] mux, input int steps,
                         input logic [31:0] expv);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, mux, a, b, 32'hDEAD0000);
    #1;
    for (int i = 0; i <= steps; i++) begin
      if (i > 0) tick;
      vec_cnt++;
      if (o_stall !== 1'b1 || o_mwreg !== 1'b0) begin
        err_cnt++;
        $display("FAIL mul_stall_cyc%0d got stall=%b wreg=%b exp 1 0", i, o_stall, o_mwreg);
      end
    end
    tick;
    vec_cnt++;
    if (o_stall !== 1'b0 || o_mwreg !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_done_cycle got stall=%b wreg=%b exp 0 0", o_stall, o_mwreg);
    end
    tick;
    vec_cnt++;
    if (o_alu !== expv || o_mwreg !== 1'b1 || o_mmux !== mux || o_rb !== b) begin
      err_cnt++;
      $display("FAIL mul_result got alu=%h wreg=%b mux=%0d rb=%h exp alu=%h mux=%0d",
               o_alu, o_mwreg, o_mmux, o_rb, expv, mux);
    end
  endtask

  task automatic finish_with_add(input logic [4:0] mux);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, mux, 32'd100, 32'd23, 32'd0);
    #1;
    vec_cnt++;
    if (o_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL add_no_stall got stall=%b exp 0", o_stall);
    end
    tick;
    vec_cnt++;
    if (o_alu !== 32'd123 || o_mwreg !== 1'b1 || o_mmux !== mux) begin
      err_cnt++;
      $display("FAIL add_after_muls got alu=%h wreg=%b mux=%0d exp 0000007b 1 %0d",
               o_alu, o_mwreg, o_mmux, mux);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd0, 32'd0, 32'd0, 32'd0);
    tick;
    vec_cnt++;
    if (o_mwreg !== 1'b0) begin
      err_cnt++;
      $display("FAIL trailing_bubble got wreg=%b exp 0", o_mwreg);
    end
  endtask

  task automatic test_mul;
    run_mul(32'h00012345, 32'h00000100, 5'd4, 32, 32'h01234500);
    run_mul(32'hFFFFFFFD, 32'd7, 5'd5, 32, 32'hFFFFFFEB);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 5'd6, 32'd9, 32'd9, 32'd0);
    #1;
    vec_cnt++;
    if (o_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_bubble_stall got %b exp 0", o_stall);
    end
    tick;
    vec_cnt++;
    if (o_alu !== 32'd0 || o_mwreg !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_bubble got alu=%h wreg=%b exp 00000000 0", o_alu, o_mwreg);
    end
  endtask

  task automatic test_back_to_back;
    run_mul(32'd6, 32'd7, 5'd10, 32, 32'd42);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32, 32'd1);
    finish_with_add(5'd12);
  endtask

  task automatic test_mul4;
    clrn_a = 1'b0;
    sel_b  = 1'b1;
    clrn_b = 1'b1;
    run_mul(32'h00012345, 32'h00000100, 5'd4, 8, 32'h01234500);
    run_mul(32'hFFFFFFFD, 32'd7, 5'd5, 8, 32'hFFFFFFEB);
    finish_with_add(5'd13);
  endtask
`else
  task automatic test_mul_disabled;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 5'd8, 32'd6, 32'd7, 32'd0);
    #1;
    vec_cnt++;
    if (o_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_disabled_stall got %b exp 0", o_stall);
    end
    tick;
    vec_cnt++;
    if (o_alu !== 32'd13 || o_mwreg !== 1'b1 || o_mmux !== 5'd8 || o_stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL mul_disabled_add got alu=%h wreg=%b mux=%0d stall=%b exp 0000000d 1 8 0",
               o_alu, o_mwreg, o_mmux, o_stall);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d exp completion", vec_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_alu;
    test_imm_sra;
`ifdef EXE_MUL_EN
    test_mul;
    test_back_to_back;
    test_mul4;
`else
    test_mul_disabled;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
